// File: rtl/data_mem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO responder: address map and STATUS layout.
package data_mem_mmio_pkg;

  localparam logic [31:0] MMIO_BASE   = 32'hFFFF_0000;
  localparam logic [31:0] TXDATA_ADDR = MMIO_BASE + 32'h0000_0000;
  localparam logic [31:0] STATUS_ADDR = MMIO_BASE + 32'h0000_0004;
  localparam logic [31:0] CYCLE_ADDR  = MMIO_BASE + 32'h0000_0008;

  localparam int unsigned FULL_BIT  = 0;
  localparam int unsigned EMPTY_BIT = 1;
  localparam int unsigned OVF_BIT   = 3;
  localparam int unsigned COUNT_LSB = 4;

endpackage

// File: rtl/data_mem_mmio_if.sv
// Load/store port from the datapath plus the transmit valid/ready stream to the consumer.
interface data_mem_mmio_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] Addr;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemWrite;
  logic [DATA_WIDTH-1:0] ReadData;
  logic [DATA_WIDTH-1:0] TxData;
  logic                  TxValid;
  logic                  TxReady;

  modport master (
    output Addr, WriteData, MemWrite, TxReady,
    input  ReadData, TxData, TxValid
  );

  modport slave (
    input  Addr, WriteData, MemWrite, TxReady,
    output ReadData, TxData, TxValid
  );
endinterface

// File: rtl/data_mem_mmio_tx_fifo.sv
// Transmit FIFO: head is the registered slot at the read pointer, so a push into an
// empty FIFO becomes visible one cycle later.
module tx_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                push,
  input  logic [DATA_WIDTH-1:0]               push_data,
  input  logic                                pop,
  output logic [DATA_WIDTH-1:0]               head,
  output logic [$clog2(FIFO_DEPTH):0]         count,
  output logic                                full,
  output logic                                empty
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Word-addressed data RAM with an MMIO window: transmit FIFO, status/overflow and a
// free-running cycle counter. Loads are combinational.
module data_mem_mmio
  import data_mem_mmio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  data_mem_mmio_if.slave bus
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] ram_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] cycle_q;
  logic                  ovf_q;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic [AW-1:0]         ram_idx;
  logic                  ram_sel, tx_sel, status_sel, cycle_sel;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH-1:0] status;

  // Byte offset within the word is dropped before every compare.
  assign word_addr  = bus.Addr & ~ADDR_WIDTH'(3);
  assign ram_idx    = bus.Addr[AW+1:2];
  assign ram_sel    = word_addr < ADDR_WIDTH'(MEM_DEPTH * 4);
  assign tx_sel     = word_addr == ADDR_WIDTH'(TXDATA_ADDR);
  assign status_sel = word_addr == ADDR_WIDTH'(STATUS_ADDR);
  assign cycle_sel  = word_addr == ADDR_WIDTH'(CYCLE_ADDR);

  assign fifo_push  = bus.MemWrite & tx_sel;
  assign fifo_pop   = bus.TxReady & ~fifo_empty;
  assign bus.TxValid = ~fifo_empty;

  tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (fifo_push),
    .push_data (bus.WriteData),
    .pop       (fifo_pop),
    .head      (bus.TxData),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    status                     = '0;
    status[COUNT_LSB +: CW]    = fifo_count;
    status[OVF_BIT]            = ovf_q;
    status[EMPTY_BIT]          = fifo_empty;
    status[FULL_BIT]           = fifo_full;
  end

  // Load mux; TXDATA and unmapped addresses read as zero.
  always_comb begin
    bus.ReadData = '0;
    if (ram_sel)         bus.ReadData = ram_q[ram_idx];
    else if (status_sel) bus.ReadData = status;
    else if (cycle_sel)  bus.ReadData = cycle_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) ram_q[i] <= '0;
    end else if (bus.MemWrite && ram_sel) begin
      ram_q[ram_idx] <= bus.WriteData;
    end
  end

  // Sticky overflow: set by a dropped push, cleared by writing 1 to its STATUS bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_q <= 1'b0;
    end else if (fifo_push && fifo_full && !fifo_pop) begin
      ovf_q <= 1'b1;
    end else if (bus.MemWrite && status_sel && bus.WriteData[OVF_BIT]) begin
      ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                          cycle_q <= '0;
    else if (bus.MemWrite && cycle_sel) cycle_q <= bus.WriteData;
    else                                cycle_q <= cycle_q + DATA_WIDTH'(1);
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboard bench for data_mem_mmio: stimulus queues expectations, monitor compares.
module tb_data_mem_mmio;
  import data_mem_mmio_pkg::*;

  typedef struct {
    string       name;
    int          kind;   // 0: ReadData, 1: TxValid
    logic [31:0] exp;
  } chk_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  data_mem_mmio_if bus ();

  data_mem_mmio dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  chk_t        chk_q [$];
  logic [31:0] tx_q  [$];
  bit          rd_req = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Monitor: reads are sampled mid-cycle; transmit words are checked when a handshake is pending.
  always @(negedge CLK) begin
    if (rd_req) begin
      n_tests++;
      if (chk_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: no expectation queued");
      end else begin
        chk_t        c;
        logic [31:0] act;
        c   = chk_q.pop_front();
        act = (c.kind == 1) ? {31'd0, bus.TxValid} : bus.ReadData;
        if (act !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", c.name, act, c.exp);
        end
      end
    end
    if (bus.TxValid && bus.TxReady) begin
      n_tests++;
      if (tx_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: got 0x%08h, expected no transfer", bus.TxData);
      end else begin
        logic [31:0] e;
        e = tx_q.pop_front();
        if (bus.TxData !== e) begin
          n_fail++;
          $display("FAIL tx_data: got 0x%08h, expected 0x%08h", bus.TxData, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input int kind, input logic [31:0] addr, input logic [31:0] exp,
                     input string name);
    chk_t c;
    c.name = name; c.kind = kind; c.exp = exp;
    bus.Addr     = addr;
    bus.MemWrite = 1'b0;
    chk_q.push_back(c);
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.Addr      = addr;
    bus.WriteData = data;
    bus.MemWrite  = 1'b1;
    cyc();
    bus.MemWrite  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Addr = '0; bus.WriteData = '0; bus.MemWrite = 1'b0; bus.TxReady = 1'b0;
    #2 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;

    // Reset state
    cyc(); cyc();
    chk(0, CYCLE_ADDR, 32'd2, "cycle_after_reset");
    chk(0, 32'h10, 32'h0, "ram_reset");
    chk(1, 32'h0, 32'h0, "txvalid_reset");
    chk(0, STATUS_ADDR, 32'h2, "status_reset");

    // RAM store/load
    wr(32'h14, 32'hDEADBEEF);
    chk(0, 32'h14, 32'hDEADBEEF, "ram_load");
    chk(0, 32'h17, 32'hDEADBEEF, "ram_load_lowbits");
    chk(0, 32'h1000, 32'h0, "unmapped_read");
    chk(0, TXDATA_ADDR, 32'h0, "txdata_read");

    // Fill, overflow, clear, drain
    for (int i = 1; i <= 4; i++) wr(TXDATA_ADDR, 32'(i));
    chk(0, STATUS_ADDR, 32'h41, "status_full");
    wr(TXDATA_ADDR, 32'd5);
    chk(0, STATUS_ADDR, 32'h49, "status_overflow");
    wr(STATUS_ADDR, 32'h8);
    chk(0, STATUS_ADDR, 32'h41, "status_ovf_clear");
    for (int i = 1; i <= 4; i++) tx_q.push_back(32'(i));
    bus.TxReady = 1'b1;
    repeat (4) cyc();
    bus.TxReady = 1'b0;
    chk(1, 32'h0, 32'h0, "txvalid_drained");
    chk(0, STATUS_ADDR, 32'h2, "status_drained");

    // Full FIFO with simultaneous push and pop
    for (int i = 5; i <= 8; i++) wr(TXDATA_ADDR, 32'(i));
    chk(0, STATUS_ADDR, 32'h41, "status_full2");
    tx_q.push_back(32'd5);
    bus.Addr = TXDATA_ADDR; bus.WriteData = 32'd9; bus.MemWrite = 1'b1; bus.TxReady = 1'b1;
    cyc();
    bus.MemWrite = 1'b0; bus.TxReady = 1'b0;
    chk(0, STATUS_ADDR, 32'h41, "status_push_pop_full");
    for (int i = 6; i <= 9; i++) tx_q.push_back(32'(i));
    bus.TxReady = 1'b1;
    repeat (4) cyc();
    bus.TxReady = 1'b0;
    chk(1, 32'h0, 32'h0, "txvalid_drained2");

    // Cycle counter load and wrap
    wr(CYCLE_ADDR, 32'hFFFF_FFFE);
    chk(0, CYCLE_ADDR, 32'hFFFF_FFFE, "cycle_load");
    chk(0, CYCLE_ADDR, 32'hFFFF_FFFF, "cycle_inc");
    chk(0, CYCLE_ADDR, 32'h0, "cycle_wrap");

    // Mid-operation asynchronous reset
    for (int i = 0; i < 3; i++) wr(TXDATA_ADDR, 32'hA0 + 32'(i));
    wr(CYCLE_ADDR, 32'd100);
    chk(0, CYCLE_ADDR, 32'd100, "cycle_100");
    chk(0, STATUS_ADDR, 32'h30, "status_three");
    chk(1, 32'h0, 32'h1, "txvalid_before_reset");
    #2 RST = 1'b0;
    chk(1, 32'h0, 32'h0, "txvalid_in_reset");
    chk(0, STATUS_ADDR, 32'h2, "status_in_reset");
    chk(0, CYCLE_ADDR, 32'h0, "cycle_in_reset");
    chk(0, 32'h14, 32'h0, "ram_in_reset");
    RST = 1'b1;
    cyc(); cyc();
    chk(0, CYCLE_ADDR, 32'd2, "cycle_after_rereset");

    n_tests++;
    if (tx_q.size() != 0 || chk_q.size() != 0) begin
      n_fail++;
      $display("FAIL queues_drained: got tx=%0d chk=%0d pending, expected 0 and 0",
               tx_q.size(), chk_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
- Word-addressed data-memory responder on the processor side of the load/store interface.
- Serves loads and stores issued by the single-cycle datapath: address from ALU result, store data, MemWrite strobe; returns ReadData in the same cycle.
- Adds a small memory-mapped I/O region: a transmit FIFO drained by an external consumer over valid/ready, a status register, and a free-running cycle counter.

Parameters:
DATA_WIDTH, 32, width of data bus and all MMIO registers
ADDR_WIDTH, 32, width of byte address bus
MEM_DEPTH, 64, number of RAM words (power of two)
FIFO_DEPTH, 4, transmit FIFO entries (power of two, >=2)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
Addr  input  ADDR_WIDTH  byte address from datapath ALU result
WriteData  input  DATA_WIDTH  store data from datapath
MemWrite  input  1  store strobe, sampled at rising CLK
ReadData  output  DATA_WIDTH  combinational load data
TxData  output  DATA_WIDTH  FIFO head word
TxValid  output  1  FIFO non-empty
TxReady  input  1  consumer accepts head when TxValid & TxReady at rising CLK

Behaviour:
- Address map (Addr[1:0] ignored everywhere; word access only):
  - RAM: 0x0000_0000 .. MEM_DEPTH*4-1, indexed by Addr[log2(MEM_DEPTH)+1:2].
  - TXDATA: 0xFFFF_0000.
  - STATUS: 0xFFFF_0004.
  - CYCLE: 0xFFFF_0008.
  - Everything else is unmapped.
- Reads:
  - Purely combinational, no side effects.
  - RAM returns the addressed word. TXDATA reads 0.
  - STATUS reads {zero-extend, count[log2(FIFO_DEPTH):0] at bits [log2(FIFO_DEPTH)+4:4], overflow bit3, 0 bit2, empty bit1, full bit0}.
  - CYCLE returns the counter value. Unmapped reads return 0.
- Writes (MemWrite=1 at rising CLK):
  - RAM: addressed word <= WriteData; visible on ReadData from the next cycle.
  - TXDATA: push WriteData when a push is accepted; otherwise drop the data and set sticky overflow.
  - STATUS: WriteData[3]=1 clears overflow; other bits ignored.
  - CYCLE: counter <= WriteData, with no increment in that cycle.
  - Unmapped writes are ignored.
- FIFO:
  - Push is accepted iff !full, or full with a pop in the same cycle.
  - Pop = TxValid & TxReady. TxData = head entry; it changes only on pop, or on a push into an empty FIFO.
  - Simultaneous push and pop when non-empty: count unchanged, order preserved.
  - Push into an empty FIFO: TxValid rises the next cycle; zero-latency bypass is not permitted.
  - Read/write pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH. full = (count == FIFO_DEPTH); empty = (count == 0).
- Cycle counter: increments by 1 every cycle when not being written; wraps 0xFFFF_FFFF -> 0.
- Reset (RST low, asynchronous, any time including mid-transfer):
  - All RAM words 0; FIFO pointers and count 0; overflow 0; counter 0.
  - TxValid=0; TxData=0.
  - ReadData reflects the reset state combinationally (e.g. RAM reads 0).
  - Pending pushes or pops in the reset cycle are lost.
  - First increment occurs on the first rising CLK after RST deasserts.

Decomposition:
- Shared package/macros file holds:
  - address constants TXDATA_ADDR, STATUS_ADDR, CYCLE_ADDR;
  - STATUS bit indices FULL_BIT=0, EMPTY_BIT=1, OVF_BIT=3, COUNT_LSB=4;
  - MMIO base 0xFFFF_0000.
- One sub-module: tx_fifo.
  - Synchronous FIFO, parameters DATA_WIDTH and FIFO_DEPTH.
  - Ports: CLK, RST, push, push_data, pop, head, count, full, empty.
- Top level: address decode, RAM array, status/overflow, cycle counter.

Test Plan:
- Reset then read: release RST; read Addr=0x10 -> ReadData=0. Read CYCLE two cycles after release -> 2. TxValid=0. STATUS=0x0000_0002.
- RAM store/load: write 0xDEADBEEF to 0x0000_0014, then read 0x14 -> 0xDEADBEEF. Read 0x17 -> 0xDEADBEEF (low bits ignored). Read 0x0000_1000 (unmapped) -> 0.
- FIFO fill and overflow with TxReady=0:
  - Push 1,2,3,4 -> STATUS=0x0000_0041 (count 4, full).
  - Push 5 -> dropped, STATUS=0x0000_0049.
  - Write STATUS 0x8 -> overflow cleared, STATUS=0x0000_0041.
  - Raise TxReady -> TxData sequence 1,2,3,4, then TxValid=0.
- Full FIFO with simultaneous push 9 and pop: push accepted, count stays 4, overflow stays 0, 9 emerges last.
- Cycle counter: write CYCLE 0xFFFF_FFFE; next cycle read -> 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0000_0000.
- Mid-operation reset: with 3 FIFO entries and the counter at 100, pulse RST low between clock edges -> TxValid drops immediately, count 0, CYCLE reads 0, RAM word 0x14 reads 0.
